// File: rtl/gate_share_arbiter.sv
// Arbiter sharing one NOR gate bank among requesters; settle, capture, pulse Done.
// Macro GATE_SHARE_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.

module ttl_7402 #(
  parameter int BLOCKS     = 4,
  parameter int WIDTH_IN   = 2,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic [BLOCKS-1:0]          Y
);

  // Delays are a timing annotation; this bank is zero-delay logic.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_neg_delay
  end

  // One NOR per block over its WIDTH_IN inputs.
  always_comb begin
    Y = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      Y[b] = ~|A_2D[b*WIDTH_IN +: WIDTH_IN];
    end
  end

endmodule

module gate_share_arbiter #(
  parameter int REQUESTERS    = 2,
  parameter int BLOCKS        = 4,
  parameter int WIDTH_IN      = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int DELAY_RISE    = 0,
  parameter int DELAY_FALL    = 0
) (
  input  logic                                   Clk,
  input  logic                                   Clear_bar,
  input  logic [REQUESTERS-1:0]                  Req,
  input  logic [REQUESTERS*BLOCKS*WIDTH_IN-1:0]  Operands,
  output logic [REQUESTERS-1:0]                  Grant,
  output logic                                   Busy,
  output logic                                   Done,
  output logic [BLOCKS-1:0]                      Result,
  output logic [$clog2(REQUESTERS)-1:0]          Result_id
);

  localparam int IDW = $clog2(REQUESTERS);
  localparam int SL  = BLOCKS * WIDTH_IN;
  localparam int CW  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDW:0] NREQ = (IDW+1)'(REQUESTERS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  start;
  logic [IDW-1:0]  next_id;
  logic            found;
  logic [IDW:0]    cand;
  logic [SL-1:0]   gate_a;
  logic [BLOCKS-1:0] gate_y;

  assign next_id = (winner == IDW'(REQUESTERS-1)) ? '0 : winner + 1'b1;

`ifdef GATE_SHARE_FIXED_PRIORITY_EN
  assign start = '0;
`else
  logic [IDW-1:0] ptr;

  assign start = ptr;

  // Round-robin pointer moves past each served requester.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      ptr <= '0;
    end else if (state == S_CAPTURE) begin
      ptr <= next_id;
    end
  end
`endif

  // First requesting index found scanning upward from start, with wrap.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      cand = {1'b0, start} + (IDW+1)'(i);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && Req[cand[IDW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDW-1:0];
      end
    end
  end

  // Only the owner's slice reaches the bank; zeros while idle.
  always_comb begin
    gate_a = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (state != S_IDLE && winner == IDW'(i)) begin
        gate_a = Operands[i*SL +: SL];
      end
    end
  end

  ttl_7402 #(
    .BLOCKS     (BLOCKS),
    .WIDTH_IN   (WIDTH_IN),
    .DELAY_RISE (DELAY_RISE),
    .DELAY_FALL (DELAY_FALL)
  ) u_bank (
    .A_2D (gate_a),
    .Y    (gate_y)
  );

  // Grant, settle countdown, capture and completion pulse.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state     <= S_IDLE;
      count     <= '0;
      winner    <= '0;
      Grant     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Result    <= '0;
      Result_id <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            winner <= pick;
            Grant  <= REQUESTERS'(1) << pick;
            Busy   <= 1'b1;
            count  <= CW'(SETTLE_CYCLES - 1);
            state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (count == '0) state <= S_CAPTURE;
          else count <= count - 1'b1;
        end
        S_CAPTURE: begin
          Result    <= gate_y;
          Result_id <= winner;
          Done      <= 1'b1;
          Grant     <= '0;
          Busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
